// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nand3_bist_pkg.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__nand3_bist_pkg.sv - shared types and constants for the nand3 BIST
//
// Purpose: state encoding, stimulus code width, last code and settle limits
//          shared by the BIST controller and anything that inspects it.
// Ports:   none (package).
package gf180mcu_fd_sc_mcu9t5v0__nand3_bist_pkg;

    // Stimulus code is {A3,A2,A1}; the run walks 0..LAST_CODE and stops there.
    localparam int CODE_W = 3;
    localparam logic [CODE_W-1:0] LAST_CODE = 3'd7;

    // Legal settle range; the counter is sized to hold SETTLE_MAX-1.
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    // A run is in progress while stimulus is being applied or checked.
    function automatic logic is_busy(input state_t s);
        return (s == ST_APPLY) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nand3_bist_func.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__nand3_bist_func.sv - functional nand3 golden model
//
// Purpose: behavioural three-input NAND used as the reference response.
// Ports:   A1, A2, A3 - inputs; ZN - ~(A1 & A2 & A3).
module gf180mcu_fd_sc_mcu9t5v0__nand3_func (
    input  logic A1,
    input  logic A2,
    input  logic A3,
    output logic ZN
);

    assign ZN = ~(A1 & A2 & A3);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nand3_bist.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__nand3_bist.sv - exhaustive stimulus/compare BIST for a nand3 cell
//
// Purpose: on START, drives codes 0..7 onto A1..A3, holds each for SETTLE+1
//          cycles, compares the cell response ZN against a golden nand3 and
//          reports PASS / first failing code, with a one-cycle DONE pulse.
// Ports:   CLK       - clock, rising edge
//          RST       - synchronous active-high reset
//          START     - run request, sampled in IDLE only
//          ZN        - response of the cell under test
//          A1,A2,A3  - stimulus code bits 0..2 (0 when not busy)
//          BUSY      - run in progress
//          DONE      - one-cycle end-of-run pulse
//          PASS      - last completed run had no mismatch
//          FAIL_CODE - first failing code {A3,A2,A1}, 0 when PASS=1
module gf180mcu_fd_sc_mcu9t5v0__nand3_bist
    import gf180mcu_fd_sc_mcu9t5v0__nand3_bist_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ZN,
    output logic              A1,
    output logic              A2,
    output logic              A3,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [CODE_W-1:0] FAIL_CODE
);

    if ((SETTLE < SETTLE_MIN) || (SETTLE > SETTLE_MAX)) begin : g_bad_settle
        $error("SETTLE out of range 1..15");
    end

    // Last APPLY count; reaching it moves to CHECK, so a code is driven for
    // SETTLE APPLY cycles plus the CHECK cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    state_t              state, state_nx;
    logic [CODE_W-1:0]   code, code_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic                pass_q, pass_nx;
    logic [CODE_W-1:0]   fail_q, fail_nx;
    logic                expected;

    gf180mcu_fd_sc_mcu9t5v0__nand3_func u_golden (
        .A1 (code[0]),
        .A2 (code[1]),
        .A3 (code[2]),
        .ZN (expected)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            code   <= '0;
            cnt    <= '0;
            pass_q <= 1'b0;
            fail_q <= '0;
        end else begin
            state  <= state_nx;
            code   <= code_nx;
            cnt    <= cnt_nx;
            pass_q <= pass_nx;
            fail_q <= fail_nx;
        end
    end

    always_comb begin
        state_nx = state;
        code_nx  = code;
        cnt_nx   = cnt;
        pass_nx  = pass_q;
        fail_nx  = fail_q;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_nx = ST_APPLY;
                    code_nx  = '0;
                    cnt_nx   = '0;
                end
            end
            ST_APPLY: begin
                if (cnt == CNT_LAST) begin
                    state_nx = ST_CHECK;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                // ZN is looked at here and nowhere else.
                if (ZN != expected) begin
                    state_nx = ST_FIN;
                    pass_nx  = 1'b0;
                    fail_nx  = code;
                end else if (code == LAST_CODE) begin
                    state_nx = ST_FIN;
                    pass_nx  = 1'b1;
                    fail_nx  = '0;
                end else begin
                    state_nx = ST_APPLY;
                    code_nx  = code + CODE_W'(1);
                    cnt_nx   = '0;
                end
            end
            ST_FIN: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign BUSY         = is_busy(state);
    assign DONE         = (state == ST_FIN);
    // Code register keeps its last value after a run; mask it outside BUSY.
    assign {A3, A2, A1} = BUSY ? code : '0;
    assign PASS         = pass_q;
    assign FAIL_CODE    = fail_q;

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__nand3_bist.md
GF180MCU_FD_SC_MCU9T5V0__NAND3_BIST -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__nand3_bist

Interface
REQ-001 Parameter SETTLE, default 2, number of settle cycles per input code before ZN is sampled; legal range 1..15.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 START  input  1  request a test run; sampled only in IDLE.
REQ-005 ZN  input  1  response from the nand3 cell under test.
REQ-006 A1  output  1  stimulus bit 0 to the cell under test.
REQ-007 A2  output  1  stimulus bit 1.
REQ-008 A3  output  1  stimulus bit 2.
REQ-009 BUSY  output  1  high while a run is in progress.
REQ-010 DONE  output  1  one-cycle pulse at the end of a run.
REQ-011 PASS  output  1  result of the last completed run; 1 means no mismatch.
REQ-012 FAIL_CODE  output  3  first failing stimulus code {A3,A2,A1}; 0 when PASS=1.

Function
REQ-013 The FSM SHALL have states IDLE, APPLY, CHECK and FIN, and SHALL leave no other state reachable.
REQ-014 In IDLE, A1/A2/A3 SHALL be 0, BUSY SHALL be 0, and PASS/FAIL_CODE SHALL hold the result of the last run.
REQ-015 On the edge where START=1 in IDLE, the block SHALL enter APPLY, set BUSY=1, load code=0, and clear the settle counter.
REQ-016 Outputs {A3,A2,A1} SHALL equal the registered code while BUSY=1.
REQ-017 In APPLY, the settle counter SHALL increment each cycle; at count SETTLE-1 the block SHALL move to CHECK, so each code is driven for exactly SETTLE+1 cycles.
REQ-018 In CHECK, ZN SHALL be compared with the expected value ~(A1&A2&A3) for the current code.
REQ-019 On a CHECK mismatch, the block SHALL record FAIL_CODE=code, set PASS=0, and go to FIN without applying further codes.
REQ-020 On a CHECK match with code<7, the block SHALL increment code, clear the counter, and return to APPLY.
REQ-021 On a CHECK match with code=7, the block SHALL set PASS=1 and FAIL_CODE=0, and go to FIN; code SHALL never wrap past 7.
REQ-022 FIN SHALL last one cycle, with DONE=1 and BUSY=0, then return to IDLE.
REQ-023 On a full passing run, DONE SHALL assert 8*(SETTLE+1) cycles after the START-sampling edge (24 for SETTLE=2).
REQ-024 START asserted while BUSY=1 or in FIN SHALL be ignored; START held high SHALL retrigger a new run only from IDLE.
REQ-025 ZN SHALL be used only in CHECK; its value in other states SHALL have no effect.

Reset
REQ-026 While RST=1 at a rising edge, the block SHALL enter IDLE with A1=A2=A3=0, BUSY=0, DONE=0, PASS=0, FAIL_CODE=0, and counter=0.
REQ-027 RST SHALL take priority over START and over any in-progress run.
REQ-028 A reset mid-run SHALL abort the run without producing a DONE pulse.

Structure
REQ-029 A shared package SHALL hold the state encoding (2-bit), the code width constant (3), the last-code constant (7), and the SETTLE range limits.
REQ-030 The expected value SHALL be produced by one instance of the existing gf180mcu_fd_sc_mcu9t5v0__nand3_func sub-module, driven from the code register, as the golden model.
REQ-031 The block SHALL use no other sub-modules and SHALL contain no latches.

Verification
REQ-032 Connect ZN to a correct nand3 with SETTLE=2, pulse START: codes 0..7 are driven for 3 cycles each, DONE pulses 24 cycles after START, PASS=1, and FAIL_CODE=0.
REQ-033 Force ZN stuck-at-1: the run stops at code 7, PASS=0, FAIL_CODE=3'b111, and DONE pulses after 24 cycles.
REQ-034 Force ZN stuck-at-0: the run fails at code 0, PASS=0, FAIL_CODE=0, and DONE pulses 3 cycles after START.
REQ-035 Assert RST during code 4 of a run: the next cycle shows IDLE, all outputs 0, and no DONE; a following START gives a full passing run.
REQ-036 Hold START high continuously with SETTLE=1: START pulses mid-run are ignored, runs repeat back-to-back with one IDLE cycle between FIN and the next APPLY, and each DONE pulse is 16 cycles after its start edge.
